// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU between two valid/ready requesters through an IDLE/EXEC/RESP sequence.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_share_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              id_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_id_q, rsp_err_q;
    logic              grant0, grant1, accept;
    logic [DATA_W-1:0] alu_res;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant1 = req1_valid && !req0_valid;
`else
    logic prio_q;  // favoured requester when both are valid
    assign grant1 = req1_valid && (!req0_valid || prio_q);
`endif
    assign grant0 = req0_valid && !grant1;

    assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op_q)
            3'b000:  alu_res = a_q & b_q;
            3'b001:  alu_res = a_q | b_q;
            3'b010:  alu_res = a_q ^ b_q;
            3'b011:  alu_res = ~(a_q | b_q);
            3'b100:  alu_res = a_q + b_q;
            3'b101:  alu_res = a_q - b_q;
            3'b110:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= grant1 ? req1_op : req0_op;
                a_q  <= grant1 ? req1_a  : req0_a;
                b_q  <= grant1 ? req1_b  : req0_b;
                id_q <= grant1;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= alu_res;
                rsp_id_q   <= id_q;
                rsp_err_q  <= (op_q == 3'b111);
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= !grant1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: per-cycle reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_data;

    int n_checks = 0;
    int n_err    = 0;

    alu_share_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a | b);
            3'd4:    return a + b;
            3'd5:    return a - b;
            3'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: one op in flight, result due two cycles after acceptance
    int          cyc = 0;
    bit          m_free = 1'b1;
    bit          m_ptr = 1'b0;
    int          m_resp_at = 0;
    logic [31:0] m_data;
    bit          m_id, m_err;
    int          acc_q[$];
    int          hs_q[$];
    logic [31:0] log_data[$];
    bit          log_id[$];
    bit          log_err[$];

    always @(negedge clk) begin
        bit g0, g1, rv;
        cyc++;
        if (!rst_n) begin
            chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
            chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
            chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_data", rsp_data, 32'd0);
            chk("rst_id_err", {30'd0, rsp_id, rsp_err}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            m_free = 1'b1;
            m_ptr  = 1'b0;
        end else begin
            g0 = 1'b0;
            g1 = 1'b0;
            if (m_free) begin
                if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    g0 = 1'b1;
`else
                    if (m_ptr) g1 = 1'b1;
                    else       g0 = 1'b1;
`endif
                end else begin
                    g0 = req0_valid;
                    g1 = req1_valid;
                end
            end
            rv = !m_free && (cyc >= m_resp_at);
            chk("ready0", {31'd0, req0_ready}, {31'd0, g0});
            chk("ready1", {31'd0, req1_ready}, {31'd0, g1});
            chk("busy", {31'd0, busy}, {31'd0, !m_free});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, rv});
            if (rv) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
            end
            if (g0 || g1) begin
                m_id      = g1;
                m_data    = g1 ? model_alu(req1_op, req1_a, req1_b)
                               : model_alu(req0_op, req0_a, req0_b);
                m_err     = g1 ? (req1_op == 3'd7) : (req0_op == 3'd7);
                m_free    = 1'b0;
                m_resp_at = cyc + 2;
                m_ptr     = !g1;
                acc_q.push_back(cyc);
            end else if (rv && rsp_ready) begin
                m_free = 1'b1;
                hs_q.push_back(cyc);
                log_data.push_back(rsp_data);
                log_id.push_back(rsp_id);
                log_err.push_back(rsp_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int who, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        bit ok = 1'b0;
        if (who == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if ((who == 0) ? req0_ready : req1_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (who == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n0, l0;
        int exp_ids[8];
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single AND from req0
        send(0, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00);
        repeat (4) tick();
        chk("and_data", log_data[0], 32'hF000F000);
        chk("and_id_err", {30'd0, log_id[0], log_err[0]}, 32'd0);
        chk("and_latency", hs_q[0] - acc_q[0], 32'd2);

        // Arithmetic wrap and signed compare from req1
        send(1, 3'd4, 32'hFFFFFFFF, 32'd1);
        send(1, 3'd5, 32'd0, 32'd1);
        send(1, 3'd6, 32'h80000000, 32'd1);
        send(1, 3'd6, 32'd1, 32'h80000000);
        repeat (4) tick();
        chk("add_wrap", log_data[1], 32'h00000000);
        chk("sub_wrap", log_data[2], 32'hFFFFFFFF);
        chk("slt_neg", log_data[3], 32'd1);
        chk("slt_pos", log_data[4], 32'd0);
        chk("arith_id", {28'd0, log_id[1], log_id[2], log_id[3], log_id[4]}, 32'hF);

        // Contention: both requesters valid for 4 ops each
        n0 = acc_q.size();
        l0 = log_id.size();
        fork
            begin
                send(0, 3'd1, 32'h0000FFFF, 32'h00FF0000);
                send(0, 3'd3, 32'h0F0F0F0F, 32'h00000000);
                send(0, 3'd2, 32'hAAAAAAAA, 32'h55555555);
                send(0, 3'd0, 32'h12345678, 32'hFFFF0000);
            end
            begin
                send(1, 3'd4, 32'h7FFFFFFF, 32'd1);
                send(1, 3'd5, 32'd5, 32'd7);
                send(1, 3'd6, 32'hFFFFFFFF, 32'd0);
                send(1, 3'd5, 32'h80000000, 32'd1);
            end
        join
        repeat (4) tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_ids = '{0, 1, 0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 7; i++) chk("issue_interval", acc_q[n0+i+1] - acc_q[n0+i], 32'd3);
`endif
        for (int i = 0; i < 8; i++)
            chk("contention_id", {31'd0, log_id[l0+i]}, exp_ids[i]);

        // Backpressure with a pending req1
        rsp_ready = 1'b0;
        l0 = log_id.size();
        fork
            send(0, 3'd4, 32'd5, 32'd7);
            begin
                repeat (2) tick();
                send(1, 3'd2, 32'h000000FF, 32'h0000000F);
            end
            begin
                for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
                repeat (5) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        repeat (4) tick();
        chk("bp_data", log_data[l0], 32'd12);
        chk("bp_next_data", log_data[l0+1], 32'h000000F0);
        chk("bp_next_id", {31'd0, log_id[l0+1]}, 32'd1);
        chk("bp_accept_gap", acc_q[acc_q.size()-1] - hs_q[hs_q.size()-2], 32'd1);

        // Reserved opcode
        l0 = log_id.size();
        send(0, 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (4) tick();
        chk("rsv_data", log_data[l0], 32'd0);
        chk("rsv_err", {31'd0, log_err[l0]}, 32'd1);

        // Reset during EXEC drops the op
        l0 = log_id.size();
        send(1, 3'd1, 32'h11111111, 32'h22222222);
        chk("exec_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_data", rsp_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick();
        chk("dropped_no_rsp", log_id.size() - l0, 32'd0);
        send(1, 3'd0, 32'h00001234, 32'h000000FF);
        repeat (4) tick();
        chk("post_rst_data", log_data[l0], 32'h00000034);
        chk("post_rst_id", {31'd0, log_id[l0]}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one 32-bit ALU datapath (bitwise AND/OR/XOR/NOR, add, subtract, signed set-less-than) between two independent requesters. Each requester issues an operation with a valid/ready handshake. The block arbitrates round-robin, sequences the operation through a registered execute stage and returns the tagged result on a single response channel. It sits between the hw3 ALU datapath and the two client units that previously owned private copies of it.

## Interface
- DATA_W, 32, operand/result width; only 32 is supported and verified.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  3  requester 0 opcode.
- req0_a, req0_b  in  DATA_W  requester 0 operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  DATA_W  result.
- rsp_id  out  1  requester that issued the op (0/1).
- rsp_err  out  1  opcode was reserved (111).
- busy  out  1  state != IDLE.

## Operation
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 NOR.
  - 100 ADD and 101 SUB: modulo 2^32, carry and overflow discarded.
  - 110 SLT: signed two's-complement A<B gives 1, else 0, zero-extended.
  - 111 reserved: rsp_data=0, rsp_err=1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid, grant one requester. Assert that requester's reqN_ready combinationally.
  - Latch op, a, b and id into the operand register. Go to EXEC.
  - If neither requester is valid, stay in IDLE.
- EXEC: compute the result and register rsp_data, rsp_id and rsp_err. Go to RESP.
- RESP:
  - Hold rsp_valid=1 with data stable until rsp_ready=1. Then go to IDLE.
  - rsp_valid stays high and data stays stable while rsp_ready is low. There is no timeout.
- Arbitration:
  - A priority pointer names the favoured requester; reset value is 0.
  - If only one requester is valid, it is granted.
  - If both are valid, the favoured requester is granted.
  - After every grant, the pointer points to the other requester.
- reqN_ready is never asserted outside IDLE, and never to both requesters in the same cycle.
- Requester inputs are sampled only at acceptance. Changes to them after acceptance do not affect the in-flight op.

## Timing
- Reset (async assert, sync release), all outputs:
  - req0_ready=0, req1_ready=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - busy=0.
  - State returns to IDLE and the priority pointer to 0.
- Latency: accept in cycle T (valid&&ready), then rsp_valid=1 from cycle T+2.
- Minimum issue interval:
  - 3 cycles (accept T, EXEC T+1, RESP T+2 with rsp_ready=1, IDLE T+3).
  - Next accept is at T+3, so peak throughput is one op per 3 cycles.
- Reset asserted mid-operation: the in-flight op is dropped with no response. The requester must reissue it.
- busy=1 in EXEC and RESP.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - When defined, arbitration is fixed priority: requester 0 always wins when both are valid, and the pointer logic is removed.
  - When undefined, arbitration is round-robin as specified above.
  - All other behaviour is identical in both builds.

## Test plan
- Single op, after reset:
  - Stimulus: req0 AND with a=0xF0F0F0F0, b=0xFF00FF00; rsp_ready=1.
  - Required: req0_ready at T; rsp_valid at T+2 with rsp_data=0xF000F000, rsp_id=0, rsp_err=0.
- Arithmetic wrap and SLT, issued from req1:
  - ADD 0xFFFFFFFF+1 gives 0x00000000.
  - SUB 0-1 gives 0xFFFFFFFF.
  - SLT a=0x80000000, b=1 gives 1.
  - SLT a=1, b=0x80000000 gives 0.
- Contention:
  - Stimulus: both requesters valid continuously for 4 ops each; rsp_ready=1.
  - Round-robin build: rsp_id sequence is 0,1,0,1,...; issue interval is exactly 3 cycles.
  - ALU_ARB_FIXED_PRIO_EN build: sequence is 0,0,0,0 then 1,1,1,1.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles during RESP.
  - Required: rsp_valid and rsp_data stable; both reqN_ready stay 0.
  - After rsp_ready=1: IDLE on the next cycle, and a pending request is accepted in that cycle.
- Reserved opcode:
  - Stimulus: op=111 with a=b=0xFFFFFFFF.
  - Required: rsp_data=0, rsp_err=1.
- Reset mid-op:
  - Stimulus: assert rst_n=0 during EXEC.
  - Required: all outputs go to reset values immediately and no response is emitted for the dropped op.
  - After release, the next req1 op is accepted normally.
